// File: rtl/const_id_pkg.sv
// Shared definitions for the constant ID checker: FSM encoding, address
// stride and index width, plus the word-address helper.
package const_id_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } stateT;

  localparam logic [31:0] ADDR_STRIDE = 32'h4;
  localparam int          IDX_W       = 2;

  // Byte address of ID word idx relative to base.
  function automatic logic [31:0] wordAddr(input logic [31:0]      base,
                                           input logic [IDX_W-1:0] idx);
    return base + ADDR_STRIDE * {{(32-IDX_W){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/const_id_timer.sv
// Saturating cycle counter used to bound the wait for a bus acknowledge.
// Clear has priority over enable; expired is high once LIMIT-1 has been
// reached, so the LIMIT-th enabled cycle is the one that sees it.
module const_id_timer #(
  parameter int LIMIT = 16,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic iCLK,
  input  logic iRSTn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  // Count enabled cycles, holding at LAST until cleared.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/const_id_checker.sv
// Read-side bus initiator that fetches NUM_REGS ID words starting at
// BaseAddr and compares each against its expected constant.
// Optional feature macro: CONST_ID_TIMEOUT_EN (abort a strobe that is not
// acknowledged within TIMEOUT_CYC cycles; without it REQ waits forever).
module const_id_checker
  import const_id_pkg::*;
#(
  parameter logic [31:0] BaseAddr    = 32'h0200_0100,
  parameter int          NUM_REGS    = 3,
  parameter logic [31:0] ID_VER1     = 32'h0123_4567,
  parameter logic [31:0] ID_VER2     = 32'h89AB_CDEF,
  parameter logic [31:0] ID_VER3     = 32'hFEDC_BA98,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic             iCLK,
  input  logic             iRSTn,
  input  logic             iSTART,
  output logic             oBUSY,
  output logic             oDONE,
  output logic             oPASS,
  output logic [IDX_W-1:0] oFAIL_IDX,
  output logic             oTIMEOUT,
  output logic [31:0]      oLAST_DAT,
  output logic [31:0]      oADR,
  input  logic [31:0]      iDAT,
  output logic             oSTB,
  output logic             oWE,
  input  logic             iACK
);

  if (NUM_REGS < 1 || NUM_REGS > 4 || TIMEOUT_CYC < 1) begin : gBadParams
    $error("const_id_checker: NUM_REGS must be 1..4 and TIMEOUT_CYC >= 1");
  end

  stateT            state;
  stateT            nextState;
  logic [IDX_W-1:0] idx;
  logic             timerExpired;
  logic             mismatch;
  logic             lastIdx;

  // Expected content of each ID word; slot 3 has no ID and reads as zero.
  function automatic logic [31:0] expectedId(input logic [IDX_W-1:0] i);
    case (i)
      2'd0:    return ID_VER1;
      2'd1:    return ID_VER2;
      2'd2:    return ID_VER3;
      default: return 32'h0;
    endcase
  endfunction

  // Case inequality so undriven or unknown read data never counts as a match.
  assign mismatch = (oLAST_DAT !== expectedId(idx));
  assign lastIdx  = (idx == IDX_W'(NUM_REGS - 1));

`ifdef CONST_ID_TIMEOUT_EN
  logic timerClr;
  logic timerEn;

  assign timerClr = (state != REQ);
  assign timerEn  = (state == REQ);

  const_id_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) uTimer (
    .iCLK    (iCLK),
    .iRSTn   (iRSTn),
    .clr     (timerClr),
    .en      (timerEn),
    .expired (timerExpired)
  );
`else
  assign timerExpired = 1'b0;
`endif

  // State register.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state and state-decoded bus/status outputs.
  always_comb begin
    nextState = state;
    oSTB      = 1'b0;
    oBUSY     = 1'b0;
    oDONE     = 1'b0;
    oWE       = 1'b0;
    case (state)
      IDLE: begin
        if (iSTART) nextState = REQ;
      end
      REQ: begin
        oSTB  = 1'b1;
        oBUSY = 1'b1;
        if (iACK)              nextState = CHECK;
        else if (timerExpired) nextState = DONE;
      end
      CHECK: begin
        oBUSY = 1'b1;
        if (mismatch || lastIdx) nextState = DONE;
        else                     nextState = REQ;
      end
      DONE: begin
        oDONE     = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Index, address, captured data and sticky result flags.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      idx       <= '0;
      oADR      <= '0;
      oLAST_DAT <= '0;
      oPASS     <= 1'b0;
      oFAIL_IDX <= '0;
      oTIMEOUT  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iSTART) begin
            idx       <= '0;
            oADR      <= wordAddr(BaseAddr, '0);
            oPASS     <= 1'b0;
            oFAIL_IDX <= '0;
            oTIMEOUT  <= 1'b0;
          end
        end
        REQ: begin
          if (iACK) begin
            oLAST_DAT <= iDAT;
          end else if (timerExpired) begin
            oTIMEOUT  <= 1'b1;
            oFAIL_IDX <= idx;
          end
        end
        CHECK: begin
          if (mismatch) begin
            oFAIL_IDX <= idx;
          end else if (lastIdx) begin
            oPASS <= 1'b1;
          end else begin
            idx  <= idx + 1'b1;
            oADR <= wordAddr(BaseAddr, idx + 1'b1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_const_id_checker.sv
// Self-checking bench for const_id_checker: a behavioural slave plus a
// transaction-level model predicting the access list, result and latency.
module tb_const_id_checker;

  localparam logic [31:0] BASE    = 32'h0200_0100;
  localparam int          NREGS   = 3;
  localparam int          TMO     = 16;
  localparam logic [31:0] NOADDR  = 32'hFFFF_FFFF;

  logic        iCLK = 1'b0;
  logic        iRSTn = 1'b0;
  logic        iSTART = 1'b0;
  logic        oBUSY, oDONE, oPASS, oTIMEOUT, oSTB, oWE;
  logic [1:0]  oFAIL_IDX;
  logic [31:0] oLAST_DAT, oADR, iDAT;
  logic        iACK;

  int checks = 0;
  int errors = 0;

  // Slave configuration.
  logic [31:0] badAddr   = NOADDR;
  logic [31:0] badVal    = 32'h0;
  logic [31:0] noAckAddr = NOADDR;
  int          ackWait   = 0;
  int          stbCnt    = 0;

  // Model state and results.
  logic [31:0] expQ[$];
  logic [31:0] modelLast = 32'h0;
  int          expDone;
  logic        expPass, expTo, expHang;
  logic [1:0]  expFail;
  int          monIdx = 0;
  int          lastN = 0;

  const_id_checker dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iSTART(iSTART), .oBUSY(oBUSY), .oDONE(oDONE),
    .oPASS(oPASS), .oFAIL_IDX(oFAIL_IDX), .oTIMEOUT(oTIMEOUT),
    .oLAST_DAT(oLAST_DAT), .oADR(oADR), .iDAT(iDAT), .oSTB(oSTB), .oWE(oWE),
    .iACK(iACK)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [31:0] idTable(input int i);
    case (i)
      0:       return 32'h0123_4567;
      1:       return 32'h89AB_CDEF;
      2:       return 32'hFEDC_BA98;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] slaveWord(input logic [31:0] a);
    if (a == badAddr) return badVal;
    case (a)
      32'h0200_0100: return 32'h0123_4567;
      32'h0200_0104: return 32'h89AB_CDEF;
      32'h0200_0108: return 32'hFEDC_BA98;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Responder: ACK (possibly same cycle) after ackWait unacknowledged strobe cycles.
  always_comb begin
    iACK = oSTB && (oADR != noAckAddr) && (stbCnt >= ackWait);
    iDAT = iACK ? slaveWord(oADR) : 32'h0;
  end

  always @(posedge iCLK) begin
    if (!oSTB || iACK) stbCnt <= 0;
    else               stbCnt <= stbCnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Per-cycle compare against the model's access list and bus invariants.
  always @(negedge iCLK) begin
    if (iRSTn) begin
      if (oWE !== 1'b0) check("we_tied_low", {31'd0, oWE}, 32'd0);
      if (oSTB && !oBUSY) check("stb_only_when_busy", {31'd0, oSTB}, 32'd0);
      if (oSTB && iACK) begin
        if (monIdx < expQ.size()) check("access_addr", oADR, expQ[monIdx]);
        else check("unexpected_access", oADR, NOADDR);
        monIdx++;
      end
    end
  end

  // Predict one check run from the slave configuration: accessed addresses,
  // outcome and the number of clock edges from the start edge to oDONE.
  task automatic buildModel();
    logic [31:0] a, w;
    expQ.delete();
    expDone = 0; expPass = 0; expTo = 0; expHang = 0; expFail = 0;
    for (int i = 0; i < NREGS; i++) begin
      a = BASE + 32'(4 * i);
      if (a == noAckAddr) begin
`ifdef CONST_ID_TIMEOUT_EN
        expDone += TMO; expTo = 1; expFail = 2'(i);
`else
        expHang = 1;
`endif
        break;
      end
      expQ.push_back(a);
      w = slaveWord(a);
      modelLast = w;
      expDone += ackWait + 2;
      if (w !== idTable(i)) begin expFail = 2'(i); break; end
      if (i == NREGS - 1) expPass = 1;
    end
  endtask

  task automatic pulseStart();
    monIdx = 0;
    @(negedge iCLK);
    check("idle_before_start", {31'd0, oBUSY}, 32'd0);
    iSTART = 1'b1;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    check("busy_after_start", {31'd0, oBUSY}, 32'd1);
    check("pass_cleared", {31'd0, oPASS}, 32'd0);
    check("first_addr", oADR, BASE);
  endtask

  // Run one check; lastN is the edge count after the start edge when oDONE rose.
  task automatic runCheck(input string name, input bit glitch);
    int n;
    bit seen;
    buildModel();
    pulseStart();
    seen = 0; n = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge iCLK); #1;
      n = k;
      if (glitch && k == 2) iSTART = 1'b1;
      if (glitch && k == 3) iSTART = 1'b0;
      if (oDONE) begin seen = 1; break; end
    end
    lastN = n;
    check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({name, "_done_edge"}, n, expDone);
    check({name, "_pass"}, {31'd0, oPASS}, {31'd0, expPass});
    check({name, "_fail_idx"}, {30'd0, oFAIL_IDX}, {30'd0, expFail});
    check({name, "_timeout"}, {31'd0, oTIMEOUT}, {31'd0, expTo});
    check({name, "_last_dat"}, oLAST_DAT, modelLast);
    check({name, "_busy_at_done"}, {31'd0, oBUSY}, 32'd0);
    check({name, "_access_count"}, monIdx, expQ.size());
    if (glitch) iSTART = 1'b1;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    check({name, "_done_one_cycle"}, {31'd0, oDONE}, 32'd0);
    check({name, "_pass_held"}, {31'd0, oPASS}, {31'd0, expPass});
    @(posedge iCLK); #1;
    check({name, "_stays_idle"}, {31'd0, oBUSY}, 32'd0);
  endtask

  task automatic applyReset();
    iRSTn = 1'b0;
    repeat (2) @(posedge iCLK);
    #1;
    check("rst_busy", {31'd0, oBUSY}, 32'd0);
    check("rst_stb", {31'd0, oSTB}, 32'd0);
    check("rst_done", {31'd0, oDONE}, 32'd0);
    check("rst_pass", {31'd0, oPASS}, 32'd0);
    check("rst_adr", oADR, 32'd0);
    check("rst_last_dat", oLAST_DAT, 32'd0);
    check("rst_fail_idx", {30'd0, oFAIL_IDX}, 32'd0);
    check("rst_timeout", {31'd0, oTIMEOUT}, 32'd0);
    modelLast = 32'h0;
    @(negedge iCLK);
    iRSTn = 1'b1;
  endtask

  initial begin
    bit hit, doneSeen;
    applyReset();

    // 1: correct IDs, same-cycle ACK. oDONE in cycle 7 counting the start cycle as 1.
    runCheck("t1", 0);
    check("t1_pin_edge", lastN, 32'd6);
    check("t1_pin_last", oLAST_DAT, 32'hFEDC_BA98);
    check("t1_pin_pass", {31'd0, oPASS}, 32'd1);

    // 2: second word corrupted; 0x0200_0108 must not be read.
    badAddr = 32'h0200_0104; badVal = 32'h89AB_CDEE;
    runCheck("t2", 0);
    check("t2_pin_fail_idx", {30'd0, oFAIL_IDX}, 32'd1);
    check("t2_pin_last", oLAST_DAT, 32'h89AB_CDEE);
    check("t2_pin_accesses", monIdx, 32'd2);
    badAddr = NOADDR;

    // 3: ACK on the third strobe cycle of every access; oDONE in cycle 13.
    ackWait = 2;
    runCheck("t3", 0);
    check("t3_pin_edge", lastN, 32'd12);
    check("t3_pin_pass", {31'd0, oPASS}, 32'd1);
    ackWait = 0;

    // 4: no ACK at the first word.
    noAckAddr = BASE;
`ifdef CONST_ID_TIMEOUT_EN
    runCheck("t4", 0);
    check("t4_pin_edge", lastN, 32'd16);
    check("t4_pin_timeout", {31'd0, oTIMEOUT}, 32'd1);
    check("t4_pin_fail_idx", {30'd0, oFAIL_IDX}, 32'd0);
`else
    buildModel();
    pulseStart();
    doneSeen = 0;
    repeat (40) begin
      @(posedge iCLK); #1;
      if (oDONE) doneSeen = 1;
    end
    check("t4_no_done", {31'd0, doneSeen}, 32'd0);
    check("t4_still_busy", {31'd0, oBUSY}, 32'd1);
    check("t4_still_stb", {31'd0, oSTB}, 32'd1);
    check("t4_no_timeout", {31'd0, oTIMEOUT}, 32'd0);
    check("t4_no_access", monIdx, 32'd0);
    noAckAddr = NOADDR;
    applyReset();
`endif
    noAckAddr = NOADDR;

    // 5: reset asserted during the second REQ.
    buildModel();
    pulseStart();
    hit = 0;
    for (int k = 0; k < 20; k++) begin
      if (oSTB && oADR == BASE + 32'h4) begin hit = 1; break; end
      @(posedge iCLK); #1;
    end
    check("t5_reached_second_req", {31'd0, hit}, 32'd1);
    #2 iRSTn = 1'b0;
    #1;
    check("t5_stb_drops", {31'd0, oSTB}, 32'd0);
    check("t5_busy_drops", {31'd0, oBUSY}, 32'd0);
    doneSeen = 0;
    repeat (3) begin
      @(posedge iCLK); #1;
      if (oDONE) doneSeen = 1;
    end
    check("t5_no_done", {31'd0, doneSeen}, 32'd0);
    modelLast = 32'h0;
    @(negedge iCLK);
    iRSTn = 1'b1;
    runCheck("t5b", 0);
    check("t5_pin_pass", {31'd0, oPASS}, 32'd1);

    // 6: start pulsed while busy and during DONE -> ignored.
    runCheck("t6", 1);
    check("t6_pin_strobes", monIdx, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
